serializer10bit_tx: RTL and testbench

Transmit-side counterpart to the 10-bit parallel capture register. The block accepts a 10-bit parallel word through a valid/ready handshake and shifts it out on a single serial line as a framed bit stream, LSB first: start bit, 10 data bits, optional parity bit, stop bit. It sits at the output boundary of a datapath. There it converts registered 10-bit words into a one-wire stream for the matching capture logic at the far end.

---
 rtl/serializer10bit_tx.sv | 164 ++++++++++++++++
 tb/tb_serializer10bit_tx.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/serializer10bit_tx.sv
// rtl/serializer10bit_tx.sv - framed LSB-first 10-bit parallel-to-serial transmitter
//
// Accepts a 10-bit word on a load/ready handshake and sends it on ser_out as
// start bit, 10 data bits (LSB first), optional even-parity bit, stop bit.
// Each serial bit lasts DIV clocks (1..255). All outputs are registered.
//
// Optional feature macro: SER10_PARITY_EN (adds PAR state and parity bit).
//
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   d_in    - parallel word, sampled on acceptance (load & ready)
//   load    - word-valid strobe
//   ready   - high in IDLE only
//   ser_out - serial line, idles high
//   busy    - high from first start-bit clock to last stop-bit clock
//   done    - one-clock pulse on the clock the block returns to IDLE

module serializer10bit_tx #(
   parameter int DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] d_in,
   input  logic       load,
   output logic       ready,
   output logic       ser_out,
   output logic       busy,
   output logic       done
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

`ifdef SER10_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t        state, state_n;
   logic [9:0]    shreg, shreg_n;
   logic [3:0]    bit_cnt, bit_cnt_n;
   logic [DW-1:0] div_cnt, div_cnt_n;
   logic          bit_end;
   logic          ser_out_n, ready_n, busy_n, done_n;

`ifdef SER10_PARITY_EN
   // Parity is taken from the word at capture time because the shift
   // register is consumed as the data bits go out.
   logic par_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         par_bit <= 1'b0;
      else if (state == IDLE && load)
         par_bit <= ^d_in;
   end
`endif

   assign bit_end = (div_cnt == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
         ser_out <= 1'b1;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         bit_cnt <= bit_cnt_n;
         div_cnt <= div_cnt_n;
         ser_out <= ser_out_n;
         ready   <= ready_n;
         busy    <= busy_n;
         done    <= done_n;
      end
   end

   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      div_cnt_n = div_cnt;
      case (state)
         IDLE: begin
            if (load) begin
               shreg_n   = d_in;
               bit_cnt_n = '0;
               div_cnt_n = '0;
               state_n   = START;
            end
         end
         START: begin
            if (bit_end) begin
               div_cnt_n = '0;
               state_n   = DATA;
            end else begin
               div_cnt_n = div_cnt + DW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               div_cnt_n = '0;
               shreg_n   = shreg >> 1;
               if (bit_cnt == 4'd9) begin
                  bit_cnt_n = '0;
`ifdef SER10_PARITY_EN
                  state_n   = PAR;
`else
                  state_n   = STOP;
`endif
               end else begin
                  bit_cnt_n = bit_cnt + 4'd1;
               end
            end else begin
               div_cnt_n = div_cnt + DW'(1);
            end
         end
`ifdef SER10_PARITY_EN
         PAR: begin
            if (bit_end) begin
               div_cnt_n = '0;
               state_n   = STOP;
            end else begin
               div_cnt_n = div_cnt + DW'(1);
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               div_cnt_n = '0;
               state_n   = IDLE;
            end else begin
               div_cnt_n = div_cnt + DW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered values line
   // up with the state they describe, with no path from load/d_in to a pin.
   always_comb begin
      ser_out_n = 1'b1;
      case (state_n)
         START:   ser_out_n = 1'b0;
         DATA:    ser_out_n = shreg_n[0];
`ifdef SER10_PARITY_EN
         PAR:     ser_out_n = par_bit;
`endif
         default: ser_out_n = 1'b1;
      endcase
      ready_n = (state_n == IDLE);
      busy_n  = (state_n != IDLE);
      done_n  = (state == STOP) && (state_n == IDLE);
   end

endmodule

// File: tb/tb_serializer10bit_tx.sv
// tb/tb_serializer10bit_tx.sv - directed self-checking bench for serializer10bit_tx

module tb_serializer10bit_tx;

`ifdef SER10_PARITY_EN
   localparam int NB = 13;
`else
   localparam int NB = 12;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] d4 = '0, d1 = '0;
   logic       load4 = 1'b0, load1 = 1'b0;
   logic       ready4, ser4, busy4, done4;
   logic       ready1, ser1, busy1, done1;

   int n_asserts = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   serializer10bit_tx #(.DIV(4)) u_div4 (
      .clk(clk), .rst_n(rst_n), .d_in(d4), .load(load4),
      .ready(ready4), .ser_out(ser4), .busy(busy4), .done(done4)
   );

   serializer10bit_tx #(.DIV(1)) u_div1 (
      .clk(clk), .rst_n(rst_n), .d_in(d1), .load(load1),
      .ready(ready1), .ser_out(ser1), .busy(busy1), .done(done1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int div, input logic ld, input logic [9:0] d);
      if (div == 1) begin load1 = ld; d1 = d; end
      else          begin load4 = ld; d4 = d; end
   endtask

   function automatic logic [15:0] obs_ser(input int div);
      return (div == 1) ? {15'd0, ser1} : {15'd0, ser4};
   endfunction

   function automatic logic [15:0] obs_stat(input int div);
      return (div == 1) ? {13'd0, busy1, ready1, done1} : {13'd0, busy4, ready4, done4};
   endfunction

   // Frame bit k: start, data LSB first, optional parity, stop.
   function automatic logic exp_bit(input logic [9:0] w, input int k);
      if (k == 0) return 1'b0;
      if (k <= 10) return w[k-1];
`ifdef SER10_PARITY_EN
      if (k == 11) return ^w;
`endif
      return 1'b1;
   endfunction

   // Accepts w, then checks every clock of the frame and the done/IDLE clock.
   // At clock pc (if >= 0) d_in is changed to pd and load is pulsed.
   task automatic run_frame(input int div, input logic [9:0] w, input int pc,
                            input logic [9:0] pd, input logic hold);
      logic [9:0] cur_d;
      cur_d = w;
      drive(div, 1'b1, w);
      tick();
      drive(div, hold, cur_d);
      for (int c = 0; c < NB * div; c++) begin
         if (c == pc) begin
            cur_d = pd;
            drive(div, 1'b1, cur_d);
         end else if (c == pc + 1) begin
            drive(div, hold, cur_d);
         end
         chk($sformatf("ser div%0d w%03h c%0d", div, w, c), obs_ser(div), {15'd0, exp_bit(w, c / div)});
         chk($sformatf("stat div%0d w%03h c%0d", div, w, c), obs_stat(div), 16'h4);
         tick();
      end
      chk($sformatf("end ser div%0d w%03h", div, w), obs_ser(div), 16'h1);
      chk($sformatf("end stat div%0d w%03h", div, w), obs_stat(div), 16'h3);
   endtask

   initial begin
      // Reset held across clock edges
      tick();
      tick();
      chk("rst ser4", obs_ser(4), 16'h1);
      chk("rst stat4", obs_stat(4), 16'h2);
      chk("rst ser1", obs_ser(1), 16'h1);
      chk("rst stat1", obs_stat(1), 16'h2);
      rst_n = 1'b1;
      tick();

      // Basic frame, DIV=4, 10'h2A5 (data bits 1,0,1,0,0,1,0,1,0,1)
      run_frame(4, 10'h2A5, -1, 10'h000, 1'b0);
`ifdef SER10_PARITY_EN
      chk("parity 2A5", {15'd0, exp_bit(10'h2A5, 11)}, 16'h1);
`endif
      tick();
      chk("after done stat4", obs_stat(4), 16'h2);

      // Input stability: d_in change + load pulse during DATA are ignored
      run_frame(4, 10'h155, 4 * 3 + 1, 10'h0AA, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stable idle ser4", obs_ser(4), 16'h1);
         chk("stable idle stat4", obs_stat(4), 16'h2);
      end

      // Asynchronous reset mid-START
      drive(4, 1'b1, 10'h3C3);
      tick();
      drive(4, 1'b0, 10'h3C3);
      tick();
      chk("mid start ser4", obs_ser(4), 16'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst ser4", obs_ser(4), 16'h1);
      chk("async rst stat4", obs_stat(4), 16'h2);
      #1;
      rst_n = 1'b1;
      tick();
      chk("post rst ser4", obs_ser(4), 16'h1);
      chk("post rst stat4", obs_stat(4), 16'h2);

      // Minimum divider, DIV=1, 10'h001
      run_frame(1, 10'h001, -1, 10'h000, 1'b0);
      tick();

      // Back-to-back, DIV=1, load held high: 3FF then 000
      run_frame(1, 10'h3FF, 3, 10'h000, 1'b1);
      run_frame(1, 10'h000, -1, 10'h000, 1'b0);
      tick();
      chk("b2b idle stat1", obs_stat(1), 16'h2);
      chk("b2b idle ser1", obs_ser(1), 16'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
